// File: rtl/abd_ram_dp_mp_if.sv
// abd_ram_dp_mp_if: dual-port RAM access bundle (two word ports plus status)
interface abd_ram_dp_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address_a, address_b;
  logic [DATA_WIDTH-1:0]   data_a, data_b, q_a, q_b;
  logic                    wren_a, wren_b, rden_a, rden_b;
  logic [DATA_WIDTH/8-1:0] byteen_a, byteen_b;
  logic                    ready, collision;
  logic [1:0]              addr_err;
  modport master (
    output address_a, data_a, wren_a, byteen_a, rden_a,
    output address_b, data_b, wren_b, byteen_b, rden_b,
    input  q_a, q_b, ready, collision, addr_err
  );
  modport slave (
    input  address_a, data_a, wren_a, byteen_a, rden_a,
    input  address_b, data_b, wren_b, byteen_b, rden_b,
    output q_a, q_b, ready, collision, addr_err
  );
endinterface

// File: rtl/abd_ram_dp_mp.sv
// abd_ram_dp_mp: true dual-port byte-enabled RAM with post-reset clear sequencer
module abd_ram_dp_mp #(
  parameter int DATA_WIDTH         = 32,
  parameter int RAM_REGISTER_COUNT = 1024,
  parameter int ADDR_WIDTH         = 10,
  parameter int WRITE_FIRST        = 0,
  parameter int CLEAR_ON_RESET     = 1
) (
  input logic           clock,
  input logic           rst_n,
  abd_ram_dp_mp_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = RAM_REGISTER_COUNT > 1 ? $clog2(RAM_REGISTER_COUNT) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_REGISTER_COUNT);
  localparam logic [IW-1:0] LAST = IW'(RAM_REGISTER_COUNT - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         clr_q, clr_d, ia, ib;
  logic                  ready_q, collision_q, collision_d;
  logic [1:0]            addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] mem [RAM_REGISTER_COUNT];
  logic                  in_a, in_b, act, we_a, we_b, same;
  logic [BW-1:0]         mask_a, mask_b;
  assign in_a = {1'b0, bus.address_a} < DEPTH;
  assign in_b = {1'b0, bus.address_b} < DEPTH;
  assign ia = bus.address_a[IW-1:0];
  assign ib = bus.address_b[IW-1:0];
  assign act = rst_n & ready_q;
  assign we_a = act & bus.wren_a & in_a;
  assign we_b = act & bus.wren_b & in_b;
  assign same = bus.address_a == bus.address_b;
  // port A owns every byte it enables, so B only keeps the bytes A leaves alone
  assign mask_a = we_a ? bus.byteen_a : '0;
  assign mask_b = we_b ? bus.byteen_b & ~(same ? mask_a : '0) : '0;
  assign bus.q_a = q_a_q;
  assign bus.q_b = q_b_q;
  assign bus.ready = ready_q;
  assign bus.collision = collision_q;
  assign bus.addr_err = addr_err_q;
  // read words, optionally forwarding this port's own write bytes
  always_comb begin
    rd_a = mem[ia];
    rd_b = mem[ib];
    for (int i = 0; i < BW; i++) begin
      rd_a[8*i +: 8] = (WRITE_FIRST != 0 && mask_a[i]) ? bus.data_a[8*i +: 8] : mem[ia][8*i +: 8];
      rd_b[8*i +: 8] = (WRITE_FIRST != 0 && we_b && bus.byteen_b[i]) ? bus.data_b[8*i +: 8] : mem[ib][8*i +: 8];
    end
  end
  // next state, read data and status pulses
  always_comb begin
    state_d = (state_q == CLEAR && clr_q == LAST) ? READY : state_q;
    clr_d = state_q == CLEAR ? clr_q + IW'(1) : clr_q;
    q_a_d = !act ? '0 : !bus.rden_a ? q_a_q : in_a ? rd_a : '0;
    q_b_d = !act ? '0 : !bus.rden_b ? q_b_q : in_b ? rd_b : '0;
    collision_d = we_a & we_b & same & |(bus.byteen_a & bus.byteen_b);
    addr_err_d = {act & (bus.rden_b | bus.wren_b) & ~in_b, act & (bus.rden_a | bus.wren_a) & ~in_a};
  end
  // control and output registers
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      clr_q       <= '0;
      ready_q     <= 1'b0;
      q_a_q       <= '0;
      q_b_q       <= '0;
      collision_q <= 1'b0;
      addr_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      ready_q     <= state_d == READY;
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      collision_q <= collision_d;
      addr_err_q  <= addr_err_d;
    end
  end
  // array: clear sequencer writes, then byte-masked port writes
  always_ff @(posedge clock) begin
    if (rst_n && state_q == CLEAR) mem[clr_q] <= '0;
    for (int i = 0; i < BW; i++) begin
      if (mask_a[i]) mem[ia][8*i +: 8] <= bus.data_a[8*i +: 8];
      if (mask_b[i]) mem[ib][8*i +: 8] <= bus.data_b[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_abd_ram_dp_mp.sv
// tb_abd_ram_dp_mp: directed checks of three RAM builds driven by shared stimulus
module tb_abd_ram_dp_mp;
  logic clock = 1'b0, rst_n = 1'b0;
  logic [3:0] aa = '0, ab = '0, ba = '0, bb = '0;
  logic [31:0] da = '0, db = '0, e;
  logic wa = 1'b0, wb = 1'b0, ra = 1'b0, rb = 1'b0;
  int checks = 0, failures = 0, n;
  always #5 clock = ~clock;
  abd_ram_dp_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) i0 (), i1 (), i2 ();
  assign {i0.address_a, i0.data_a, i0.wren_a, i0.byteen_a, i0.rden_a, i0.address_b, i0.data_b, i0.wren_b, i0.byteen_b, i0.rden_b} = {aa, da, wa, ba, ra, ab, db, wb, bb, rb};
  assign {i1.address_a, i1.data_a, i1.wren_a, i1.byteen_a, i1.rden_a, i1.address_b, i1.data_b, i1.wren_b, i1.byteen_b, i1.rden_b} = {aa, da, wa, ba, ra, ab, db, wb, bb, rb};
  assign {i2.address_a, i2.data_a, i2.wren_a, i2.byteen_a, i2.rden_a, i2.address_b, i2.data_b, i2.wren_b, i2.byteen_b, i2.rden_b} = {aa, da, wa, ba, ra, ab, db, wb, bb, rb};
  abd_ram_dp_mp #(.DATA_WIDTH(32), .RAM_REGISTER_COUNT(16), .ADDR_WIDTH(4), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    u0 (.clock(clock), .rst_n(rst_n), .bus(i0));
  abd_ram_dp_mp #(.DATA_WIDTH(32), .RAM_REGISTER_COUNT(16), .ADDR_WIDTH(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    u1 (.clock(clock), .rst_n(rst_n), .bus(i1));
  abd_ram_dp_mp #(.DATA_WIDTH(32), .RAM_REGISTER_COUNT(12), .ADDR_WIDTH(4), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    u2 (.clock(clock), .rst_n(rst_n), .bus(i2));
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_ready", {31'd0, i0.ready}, 0);
    chk("rst_q_a", i0.q_a, 0);
    chk("rst_q_b", i0.q_b, 0);
    chk("rst_collision", {31'd0, i0.collision}, 0);
    chk("rst_addr_err", {30'd0, i0.addr_err}, 0);
    rst_n = 1'b1;
    n = 0;
    while (i0.ready !== 1'b1 && n < 64) begin
      tick;
      n++;
    end
    chk("clear_len_first", n, 16);
    chk("ready_depth12", {31'd0, i2.ready}, 1);
    for (int i = 0; i < 16; i++) begin
      aa = 4'(i); da = 32'hFFFF0000 | i; wa = 1'b1; ba = 4'hF;
      tick;
    end
    wa = 1'b0; ra = 1'b1; aa = 4'd9;
    tick;
    chk("preload_word9", i0.q_a, 32'hFFFF0009);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; aa = 4'd9;
    chk("pulse_rst_q_a", i0.q_a, 0);
    n = 0;
    while (i0.ready !== 1'b1 && n < 64) begin
      tick;
      n++;
      if (i0.ready !== 1'b1) chk("q_a_held_in_clear", i0.q_a, 0);
    end
    chk("clear_len_pulse", n, 16);
    for (int i = 0; i < 16; i++) begin
      aa = 4'(i);
      tick;
      chk("cleared_word", i0.q_a, 0);
    end
    ra = 1'b0;
    aa = 4'd5; da = 32'hAABBCCDD; wa = 1'b1; ba = 4'b1111;
    tick;
    da = 32'h11223344; ba = 4'b0101;
    tick;
    wa = 1'b0; ab = 4'd5; rb = 1'b1;
    tick;
    chk("byteen_merge", i0.q_b, 32'hAA22CC44);
    rb = 1'b0;
    tick;
    chk("q_b_hold", i0.q_b, 32'hAA22CC44);
    wa = 1'b1; ba = 4'b0000; da = 32'h0;
    tick;
    wa = 1'b0; rb = 1'b1;
    tick;
    chk("byteen_zero_noop", i0.q_b, 32'hAA22CC44);
    rb = 1'b0;
    aa = 4'd3; da = 32'h12345678; wa = 1'b1; ba = 4'hF;
    tick;
    da = 32'hDEADBEEF; ra = 1'b1; ab = 4'd3; rb = 1'b1;
    tick;
    chk("rdw_old_q_a", i0.q_a, 32'h12345678);
    chk("rdw_new_q_a", i1.q_a, 32'hDEADBEEF);
    chk("cross_old_wf0", i0.q_b, 32'h12345678);
    chk("cross_old_wf1", i1.q_b, 32'h12345678);
    wa = 1'b0; rb = 1'b0;
    tick;
    chk("rdw_written", i0.q_a, 32'hDEADBEEF);
    ra = 1'b0;
    aa = 4'd7; da = 32'h000000AA; ba = 4'b0001; wa = 1'b1;
    ab = 4'd7; db = 32'h0000BB00; bb = 4'b0010; wb = 1'b1;
    tick;
    chk("disjoint_no_collision", {31'd0, i0.collision}, 0);
    wa = 1'b0; wb = 1'b0; ra = 1'b1;
    tick;
    chk("disjoint_merge", i0.q_a, 32'h0000BBAA);
    ra = 1'b0;
    da = 32'h1; db = 32'h2; ba = 4'hF; bb = 4'hF; wa = 1'b1; wb = 1'b1;
    tick;
    chk("collision_pulse", {31'd0, i0.collision}, 1);
    wa = 1'b0; wb = 1'b0; ra = 1'b1;
    tick;
    chk("collision_clears", {31'd0, i0.collision}, 0);
    chk("collision_a_wins", i0.q_a, 32'h00000001);
    chk("collision_a_wins_d12", i2.q_a, 32'h00000001);
    ra = 1'b0;
    aa = 4'd13; da = 32'hCAFEF00D; ba = 4'hF; wa = 1'b1;
    tick;
    chk("oor_write_err", {30'd0, i2.addr_err}, 2'b01);
    wa = 1'b0; ra = 1'b1;
    tick;
    chk("oor_read_q", i2.q_a, 0);
    chk("oor_read_err", {30'd0, i2.addr_err}, 2'b01);
    chk("inrange_no_err", {30'd0, i0.addr_err}, 0);
    ra = 1'b0; ab = 4'd14; rb = 1'b1;
    tick;
    chk("oor_b_err", {30'd0, i2.addr_err}, 2'b10);
    rb = 1'b0;
    tick;
    chk("idle_no_err", {30'd0, i2.addr_err}, 0);
    ra = 1'b1;
    for (int i = 0; i < 12; i++) begin
      aa = 4'(i);
      e = i == 3 ? 32'hDEADBEEF : i == 5 ? 32'hAA22CC44 : i == 7 ? 32'h1 : 32'h0;
      tick;
      chk("d12_word_unchanged", i2.q_a, e);
    end
    ra = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (8) tick;
    chk("mid_clear_not_ready", {31'd0, i0.ready}, 0);
    rst_n = 1'b0;
    tick;
    chk("restart_not_ready", {31'd0, i0.ready}, 0);
    rst_n = 1'b1; ra = 1'b1; aa = 4'd3;
    n = 0;
    while (i0.ready !== 1'b1 && n < 64) begin
      tick;
      n++;
      if (i0.ready !== 1'b1) chk("rden_ignored_in_clear", i0.q_a, 0);
    end
    chk("clear_len_restart", n, 16);
    tick;
    chk("word3_cleared", i0.q_a, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/abd_ram_dp_mp.md
Name: abd_ram_dp_mp

Overview:
- Parametrised single-clock true dual-port RAM. It is the next generation of the core's data/instruction memory.
- Adds the following over the previous memory block:
  - configurable depth and address width
  - per-byte write enables
  - read enables with output hold
  - selectable read-during-write mode
  - deterministic write-collision resolution
  - out-of-range detection
  - a post-reset clear sequencer that zeroes the array
- Sits between the CPU load/store/fetch paths (port A) and the debug/DMA loader (port B).

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- RAM_REGISTER_COUNT, 1024, number of words. Need not be a power of 2.
- ADDR_WIDTH, 10, address width. Must satisfy 2**ADDR_WIDTH >= RAM_REGISTER_COUNT.
- WRITE_FIRST, 0, same-port read-during-write mode. 0 = return old data; 1 = return newly written data.
- CLEAR_ON_RESET, 1, selects the post-reset behaviour. 1 = zero the array after reset; 0 = skip clearing and go straight to READY.

Ports:
- clock, input, 1, single clock for both ports. All logic is posedge.
- rst_n, input, 1, synchronous active-low reset.
- address_a, input, ADDR_WIDTH, port A word address.
- data_a, input, DATA_WIDTH, port A write data.
- wren_a, input, 1, port A write enable.
- byteen_a, input, DATA_WIDTH/8, port A byte enables. Bit i qualifies data_a[8i+7:8i].
- rden_a, input, 1, port A read enable.
- q_a, output, DATA_WIDTH, port A registered read data.
- address_b, data_b, wren_b, byteen_b, rden_b, q_b: as for port A.
- ready, output, 1, high when the array accepts accesses.
- collision, output, 1, registered one-cycle pulse on a same-address dual write.
- addr_err, output, 2, registered pulse per port for an out-of-range access. Bit 0 = A, bit 1 = B.

Behaviour:
- Reset (rst_n low at a posedge):
  - q_a, q_b, collision, addr_err all go to 0; ready goes to 0.
  - The clear counter goes to 0.
  - The FSM goes to CLEAR when CLEAR_ON_RESET=1, otherwise to READY.
  - Array contents are not reset directly.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each cycle writes 0 to word clr_cnt, then increments clr_cnt.
  - At clr_cnt == RAM_REGISTER_COUNT-1, writes the last word and moves to READY on the next edge.
  - Clearing therefore takes exactly RAM_REGISTER_COUNT cycles after reset deassertion.
  - All port inputs are ignored: no writes, q held at 0, no collision or addr_err pulses.
- READY state:
  - ready is 1 and stays in READY until reset.
  - rst_n low during CLEAR restarts the clear from word 0.
- Write:
  - When wren_x is set and the address is in range, each byte with byteen_x[i]=1 is updated at the posedge.
  - Bytes with byteen_x[i]=0 keep their value.
  - wren_x with byteen_x=0 is a no-op.
- Read:
  - When rden_x is set and the address is in range, q_x = mem[address_x] one cycle later (latency 1).
  - When rden_x=0, q_x holds its previous value.
- Same-port read and write in one cycle:
  - WRITE_FIRST=0: q_x returns the pre-write word.
  - WRITE_FIRST=1: q_x returns the merged word (old bytes, with enabled bytes replaced by new data).
- Cross-port read of an address the other port writes in the same cycle: always returns old data.
- Dual write to the same address:
  - Byte-wise merge. Where both ports enable a byte, port A's data wins; bytes enabled by only one port take that port's data.
  - collision pulses 1 the next cycle only if the two byte-enable masks overlap.
- Out of range (address >= RAM_REGISTER_COUNT):
  - The write is dropped.
  - A read loads q_x = 0.
  - addr_err[x] pulses the next cycle when rden_x or wren_x was set; no pulse for an idle port.
- collision and addr_err are single-cycle pulses, cleared the following cycle unless the condition repeats.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1: preload nonzero via a prior run, then pulse rst_n low for 1 cycle → ready=0 for exactly 16 cycles, then 1; reads of words 0..15 return 0x00000000.
- Byte enables: port A writes 0xAABBCCDD to addr 5 with byteen 4'b1111, then 0x11223344 with byteen 4'b0101; port B reads addr 5 → q_b=0xAA22CC44 one cycle after rden_b.
- Read-during-write on port A, addr 3 old=0x12345678, write 0xDEADBEEF: WRITE_FIRST=0 gives q_a=0x12345678; WRITE_FIRST=1 gives q_a=0xDEADBEEF. Port B reading addr 3 in the same cycle gives 0x12345678 in both builds.
- Dual write, addr 7: A writes 0x000000AA with byteen 4'b0001, B writes 0x0000BB00 with byteen 4'b0010 → word 0x0000BBAA, collision=0. Repeat with both byteen 4'b1111, A=0x1, B=0x2 → word 0x00000001, collision=1 for one cycle.
- DEPTH=12, ADDR_WIDTH=4: write addr 13 then read addr 13 → q_a=0 and addr_err=2'b01 pulsed on each access; words 0..11 unchanged.
- Reset during clear: assert rst_n low at clear cycle 8 → the clear restarts, ready rises 16 cycles after the deassertion edge, and rden_a=1 is ignored while ready=0 (q_a stays 0).
